// File: rtl/rom_bus_pkg.sv
// Shared timing constants and types for the bit-serial ROM bus (control and ROM ends).
package rom_bus_pkg;

  localparam int unsigned WORD_LEN = 56;
  localparam int unsigned ADR_T0   = 19;
  localparam int unsigned ADR_W    = 8;
  localparam int unsigned IS_T0    = 45;
  localparam int unsigned INST_W   = 10;
  localparam int unsigned FLAG_T   = 11;
  localparam int unsigned SYNC_T0  = 45;
  localparam int unsigned SYNC_T1  = 54;

  localparam int unsigned BT_W     = 6;
  localparam int unsigned ADR_T1   = ADR_T0 + ADR_W - 1;
  localparam int unsigned IS_T1    = IS_T0 + INST_W - 1;

  typedef logic [BT_W-1:0]   bt_t;
  typedef logic [ADR_W-1:0]  adr_t;
  typedef logic [INST_W-1:0] inst_t;

  // True when bit time t lies in the inclusive window lo..hi.
  function automatic logic in_win(input bt_t t, input int unsigned lo, input int unsigned hi);
    return (t >= BT_W'(lo)) && (t <= BT_W'(hi));
  endfunction

endpackage

// File: rtl/rom_bus_timer.sv
// Free-running word counter with decoded bus strobes and registered word sync.
module rom_bus_timer
  import rom_bus_pkg::*;
(
  input  logic clk_i,
  input  logic rst_ni,
  output bt_t  bit_time_o,
  output logic sync_o,
  output logic t11_c,
  output logic t18_c,
  output logic addr_win_c,
  output logic is_win_c,
  output logic t55_c
);

  bt_t  cnt_q, cnt_d;
  logic sync_q, sync_d;

  // Next count wraps at the end of the word; sync is decoded from the next count so it stays aligned.
  always_comb begin
    cnt_d  = cnt_q + BT_W'(1);
    if (cnt_q == BT_W'(WORD_LEN - 1)) begin
      cnt_d = '0;
    end
    sync_d = in_win(cnt_d, SYNC_T0, SYNC_T1);
  end

  // Counter and sync registers.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q  <= '0;
      sync_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      sync_q <= sync_d;
    end
  end

  // Strobes describe the bit time currently in progress, i.e. the edge that ends it.
  always_comb begin
    t11_c      = (cnt_q == BT_W'(FLAG_T));
    t18_c      = (cnt_q == BT_W'(ADR_T0 - 1));
    addr_win_c = in_win(cnt_q, ADR_T0, ADR_T1);
    is_win_c   = in_win(cnt_q, IS_T0, IS_T1);
    t55_c      = (cnt_q == BT_W'(WORD_LEN - 1));
  end

  assign bit_time_o = cnt_q;
  assign sync_o     = sync_q;

endmodule

// File: rtl/ct_rom_link.sv
// Control-side initiator of the ROM bus: program counter, address transmit, instruction receive.
module ct_rom_link
  import rom_bus_pkg::*;
(
  input  logic              cph2,
  input  logic              pon,
  input  logic              is,
  output logic              ia,
  output logic              sync,
  output logic [BT_W-1:0]   bit_time,
  output logic [ADR_W-1:0]  pc,
  input  logic              jump_wr,
  input  logic [ADR_W-1:0]  jump_adr,
  input  logic              hold,
  output logic [INST_W-1:0] inst,
  output logic              inst_valid,
  output logic              rom_ok
);

  logic t11, t18, addr_win, is_win, t55;

  adr_t  pc_q, pc_d;
  adr_t  sr_q, sr_d;
  logic  ia_q, ia_d;
  inst_t rx_q, rx_d;
  inst_t inst_q, inst_d;
  logic  inst_valid_q, inst_valid_d;
  logic  rom_ok_q, rom_ok_d;
  logic  pend_vld_q, pend_vld_d;
  adr_t  pend_adr_q, pend_adr_d;
  logic  first_q, first_d;

  rom_bus_timer u_timer (
    .clk_i      (cph2),
    .rst_ni     (pon),
    .bit_time_o (bit_time),
    .sync_o     (sync),
    .t11_c      (t11),
    .t18_c      (t18),
    .addr_win_c (addr_win),
    .is_win_c   (is_win),
    .t55_c      (t55)
  );

  // Next-state logic for shift registers, jump handshake and PC.
  always_comb begin
    pc_d         = pc_q;
    sr_d         = sr_q;
    ia_d         = 1'b0;
    rx_d         = rx_q;
    inst_d       = inst_q;
    inst_valid_d = 1'b0;
    rom_ok_d     = rom_ok_q;
    pend_vld_d   = pend_vld_q;
    pend_adr_d   = pend_adr_q;
    first_d      = first_q;

    // Last jump request in a word wins.
    if (jump_wr) begin
      pend_vld_d = 1'b1;
      pend_adr_d = jump_adr;
    end

    if (t11) begin
      rom_ok_d = is;
    end

    // Load the address so bit 0 is on ia during the first address bit time.
    if (t18) begin
      sr_d = pc_q;
      ia_d = pc_q[0];
    end

    // Zero fill means sr_q[1] is already 0 when the last address bit ends.
    if (addr_win) begin
      sr_d = sr_q >> 1;
      ia_d = sr_q[1];
    end

    if (is_win) begin
      rx_d = {is, rx_q[INST_W-1:1]};
    end

    // Word boundary: deliver instruction and update PC once the ROM is known to be aligned.
    if (t55) begin
      first_d = 1'b0;
      if (!first_q) begin
        inst_d       = rx_q;
        inst_valid_d = 1'b1;
        if (jump_wr || pend_vld_q) begin
          pc_d       = jump_wr ? jump_adr : pend_adr_q;
          pend_vld_d = 1'b0;
        end else if (!hold) begin
          pc_d = pc_q + ADR_W'(1);
        end
      end
    end
  end

  // State registers.
  always_ff @(posedge cph2 or negedge pon) begin
    if (!pon) begin
      pc_q         <= '0;
      sr_q         <= '0;
      ia_q         <= 1'b0;
      rx_q         <= '0;
      inst_q       <= '0;
      inst_valid_q <= 1'b0;
      rom_ok_q     <= 1'b0;
      pend_vld_q   <= 1'b0;
      pend_adr_q   <= '0;
      first_q      <= 1'b1;
    end else begin
      pc_q         <= pc_d;
      sr_q         <= sr_d;
      ia_q         <= ia_d;
      rx_q         <= rx_d;
      inst_q       <= inst_d;
      inst_valid_q <= inst_valid_d;
      rom_ok_q     <= rom_ok_d;
      pend_vld_q   <= pend_vld_d;
      pend_adr_q   <= pend_adr_d;
      first_q      <= first_d;
    end
  end

  assign pc         = pc_q;
  assign ia         = ia_q;
  assign inst       = inst_q;
  assign inst_valid = inst_valid_q;
  assign rom_ok     = rom_ok_q;

endmodule

// File: tb/tb_ct_rom_link.sv
// Directed bench for ct_rom_link with a behavioural ROM whose address k holds k+3.
module tb_ct_rom_link;

  logic       cph2;
  logic       pon;
  logic       rom_is;
  logic       ia;
  logic       sync;
  logic [5:0] bit_time;
  logic [7:0] pc;
  logic       jump_wr;
  logic [7:0] jump_adr;
  logic       hold;
  logic [9:0] inst;
  logic       inst_valid;
  logic       rom_ok;

  int n_vec = 0;
  int n_err = 0;

  logic       mon_en;
  logic       flag_en;
  logic [5:0] tb_bt;
  logic [7:0] rom_adr;
  logic [9:0] rom_tx;

  ct_rom_link dut (
    .cph2       (cph2),
    .pon        (pon),
    .is         (rom_is),
    .ia         (ia),
    .sync       (sync),
    .bit_time   (bit_time),
    .pc         (pc),
    .jump_wr    (jump_wr),
    .jump_adr   (jump_adr),
    .hold       (hold),
    .inst       (inst),
    .inst_valid (inst_valid),
    .rom_ok     (rom_ok)
  );

  initial cph2 = 1'b0;
  always #5 cph2 = ~cph2;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  // Reference bit-time count, restarting with pon.
  always @(posedge cph2 or negedge pon) begin
    if (!pon) tb_bt <= '0;
    else      tb_bt <= (tb_bt == 6'd55) ? 6'd0 : tb_bt + 6'd1;
  end

  // ROM model: capture address LSB-first, return instruction during 45..54, flag at 11.
  always @(negedge cph2) begin
    if (tb_bt >= 6'd19 && tb_bt <= 6'd26) rom_adr = {ia, rom_adr[7:1]};
    if (tb_bt == 6'd27) rom_tx = 10'(rom_adr) + 10'd3;
    if (tb_bt == 6'd11) begin
      rom_is = flag_en;
    end else if (tb_bt >= 6'd45 && tb_bt <= 6'd54) begin
      rom_is = rom_tx[0];
      rom_tx = rom_tx >> 1;
    end else begin
      rom_is = 1'b0;
    end
  end

  // Counter and sync tracking every cycle.
  always @(negedge cph2) begin
    if (mon_en) begin
      check("bit_time", 32'(bit_time), 32'(tb_bt));
      check("sync", 32'(sync), 32'(tb_bt >= 6'd45 && tb_bt <= 6'd54));
    end
  end

  task automatic goto_bt(input int t);
    int n;
    n = 0;
    while (int'(tb_bt) != t && n < 200) begin
      @(negedge cph2);
      n++;
    end
    check("goto_bt", 32'(tb_bt), 32'(t));
  endtask

  // Runs through the word boundary; returns sampling bit time 0 of the next word.
  task automatic end_word();
    goto_bt(55);
    @(negedge cph2);
  endtask

  task automatic get_adr(output logic [7:0] a);
    goto_bt(19);
    for (int k = 0; k < 8; k++) begin
      a[k] = ia;
      @(negedge cph2);
    end
    check("ia_idle_t27", 32'(ia), 32'd0);
  endtask

  task automatic pulse_jump(input logic [7:0] a);
    jump_wr  = 1'b1;
    jump_adr = a;
    @(negedge cph2);
    jump_wr  = 1'b0;
  endtask

  logic [7:0] adr;

  initial begin
    pon      = 1'b0;
    jump_wr  = 1'b0;
    jump_adr = '0;
    hold     = 1'b0;
    flag_en  = 1'b1;
    mon_en   = 1'b0;
    rom_adr  = '0;
    rom_tx   = '0;
    repeat (3) @(negedge cph2);
    check("rst_bit_time", 32'(bit_time), 32'd0);
    check("rst_pc", 32'(pc), 32'd0);
    check("rst_ia", 32'(ia), 32'd0);
    check("rst_sync", 32'(sync), 32'd0);
    check("rst_inst", 32'(inst), 32'd0);
    check("rst_inst_valid", 32'(inst_valid), 32'd0);
    check("rst_rom_ok", 32'(rom_ok), 32'd0);

    pon    = 1'b1;
    mon_en = 1'b1;

    // Word 0: first word, nothing delivered, pc held.
    end_word();
    check("w0_inst_valid", 32'(inst_valid), 32'd0);
    check("w0_pc", 32'(pc), 32'd0);
    check("w0_inst", 32'(inst), 32'd0);

    // Word 1: address 0, instruction 3, pc advances.
    check("w1_rom_ok", 32'(rom_ok), 32'd1);
    get_adr(adr);
    check("w1_adr", 32'(adr), 32'h00);
    end_word();
    check("w1_inst_valid", 32'(inst_valid), 32'd1);
    check("w1_inst", 32'(inst), 32'h003);
    check("w1_pc", 32'(pc), 32'h01);
    @(negedge cph2);
    check("w1_valid_pulse", 32'(inst_valid), 32'd0);

    // Word 2: jump to 0xFF.
    get_adr(adr);
    check("w2_adr", 32'(adr), 32'h01);
    goto_bt(30);
    pulse_jump(8'hFF);
    end_word();
    check("w2_pc", 32'(pc), 32'hFF);
    check("w2_inst", 32'(inst), 32'h004);

    // Word 3: pc wraps 0xFF -> 0x00.
    get_adr(adr);
    check("w3_adr", 32'(adr), 32'hFF);
    end_word();
    check("w3_pc_wrap", 32'(pc), 32'h00);
    check("w3_inst", 32'(inst), 32'h102);

    // Word 4: two jumps, last one wins.
    get_adr(adr);
    check("w4_adr", 32'(adr), 32'h00);
    goto_bt(30);
    pulse_jump(8'h5A);
    goto_bt(40);
    pulse_jump(8'h21);
    end_word();
    check("w4_pc_last_jump", 32'(pc), 32'h21);
    check("w4_inst", 32'(inst), 32'h003);

    // Word 5: pending cleared, normal increment.
    get_adr(adr);
    check("w5_adr", 32'(adr), 32'h21);
    end_word();
    check("w5_pc_pend_clr", 32'(pc), 32'h22);
    check("w5_inst", 32'(inst), 32'h024);

    // Word 6: jump_wr coincident with the update edge.
    goto_bt(55);
    pulse_jump(8'h77);
    check("w6_pc_jump_t55", 32'(pc), 32'h77);
    check("w6_inst", 32'(inst), 32'h025);

    // Word 7: hold keeps pc.
    goto_bt(50);
    hold = 1'b1;
    end_word();
    hold = 1'b0;
    check("w7_pc_hold", 32'(pc), 32'h77);
    check("w7_inst", 32'(inst), 32'h07A);

    // Word 8: same address retransmitted; pending jump beats hold.
    get_adr(adr);
    check("w8_adr_retx", 32'(adr), 32'h77);
    goto_bt(30);
    pulse_jump(8'h10);
    goto_bt(55);
    hold = 1'b1;
    @(negedge cph2);
    hold = 1'b0;
    check("w8_pc_jump_over_hold", 32'(pc), 32'h10);
    check("w8_inst", 32'(inst), 32'h07A);

    // Word 9: ROM absent flag, word 10: present again.
    flag_en = 1'b0;
    goto_bt(12);
    check("w9_rom_ok_low", 32'(rom_ok), 32'd0);
    flag_en = 1'b1;
    end_word();
    check("w9_pc", 32'(pc), 32'h11);
    goto_bt(12);
    check("w10_rom_ok_high", 32'(rom_ok), 32'd1);

    // Mid-word power-on reset during instruction receive.
    goto_bt(50);
    mon_en = 1'b0;
    pon    = 1'b0;
    #1;
    check("por_bit_time", 32'(bit_time), 32'd0);
    check("por_pc", 32'(pc), 32'd0);
    check("por_ia", 32'(ia), 32'd0);
    check("por_sync", 32'(sync), 32'd0);
    check("por_inst", 32'(inst), 32'd0);
    check("por_inst_valid", 32'(inst_valid), 32'd0);
    check("por_rom_ok", 32'(rom_ok), 32'd0);
    @(negedge cph2);
    pon    = 1'b1;
    mon_en = 1'b1;
    end_word();
    check("por_w0_inst_valid", 32'(inst_valid), 32'd0);
    check("por_w0_pc", 32'(pc), 32'd0);
    get_adr(adr);
    check("por_w1_adr", 32'(adr), 32'h00);
    end_word();
    check("por_w1_inst_valid", 32'(inst_valid), 32'd1);
    check("por_w1_inst", 32'(inst), 32'h003);
    check("por_w1_pc", 32'(pc), 32'h01);

    mon_en = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
